ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte from the CPU (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain PS2_CLK/PS2_DATA lines. It sits beside the existing PS/2 keyboard receiver on cpu_clk (10 MHz) and drives the pins only through pull-low enables. The board top combines these enables into tri-states. busy tells the receiver to ignore line activity during a host frame.

---
 rtl/ps2_host_tx_pkg.sv | 24 ++
 rtl/ps2_line_sync.sv | 33 +++
 rtl/ps2_host_tx.sv | 145 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: controller states, frame length, common keyboard commands.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } state_t;

  localparam int PS2_FRAME_BITS = 11;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // Frame in transmit order from bit 0: start(0), data LSB first, odd parity, stop(1).
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a falling-edge pulse on clock.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a false fall after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_in};
      data_ff  <= {data_ff[0], data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, clocked frame out, ACK check, timeout.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 1000,
  parameter int REQ_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES = 150000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       w_enable,
  input  logic [7:0] w_data_in,
  output logic       w_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);

  localparam int PW = $clog2(INHIBIT_CYCLES > REQ_CYCLES ? INHIBIT_CYCLES : REQ_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] REQ_LAST     = PW'(REQ_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT_CYCLES - 1);

  state_t                    state;
  logic [PW-1:0]             phase_cnt;
  logic [TW-1:0]             tmo_cnt;
  logic [3:0]                bit_idx;
  logic [PS2_FRAME_BITS-1:0] frame;
  logic                      nack;
  logic                      clk_sync;
  logic                      data_sync;
  logic                      clk_fall;
  logic                      in_frame;
  logic                      tmo_hit;

  ps2_line_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .clk_in    (ps2_clk_in),
    .data_in   (ps2_data_in),
    .clk_sync  (clk_sync),
    .data_sync (data_sync),
    .clk_fall  (clk_fall)
  );

  assign in_frame = (state == ST_SEND) || (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      phase_cnt   <= '0;
      tmo_cnt     <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      nack        <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      w_ready     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;
      // Timeout outranks any edge activity seen in the same cycle.
      if (tmo_hit) begin
        ps2_clk_oe  <= 1'b0;
        ps2_data_oe <= 1'b0;
        done        <= 1'b1;
        timeout_err <= 1'b1;
        busy        <= 1'b0;
        state       <= ST_IDLE;
      end else begin
        if (in_frame) tmo_cnt <= tmo_cnt + 1'b1;
        case (state)
          ST_IDLE: begin
            w_ready <= 1'b1;
            busy    <= 1'b0;
            if (w_enable && w_ready) begin
              frame      <= ps2_frame(w_data_in);
              w_ready    <= 1'b0;
              busy       <= 1'b1;
              ps2_clk_oe <= 1'b1;
              phase_cnt  <= '0;
              state      <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (phase_cnt == INHIBIT_LAST) begin
              phase_cnt   <= '0;
              ps2_data_oe <= 1'b1;
              state       <= ST_REQ;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          ST_REQ: begin
            if (phase_cnt == REQ_LAST) begin
              ps2_clk_oe <= 1'b0;
              tmo_cnt    <= '0;
              bit_idx    <= '0;
              state      <= ST_SEND;
            end else begin
              phase_cnt <= phase_cnt + 1'b1;
            end
          end
          ST_SEND: begin
            // bit_idx names the bit on the wire; index 10 (stop) releases data.
            if (clk_fall) begin
              bit_idx     <= bit_idx + 4'd1;
              ps2_data_oe <= ~frame[bit_idx + 4'd1];
              if (bit_idx == 4'd9) state <= ST_ACK;
            end
          end
          ST_ACK: begin
            ps2_data_oe <= 1'b0;
            if (clk_fall) begin
              nack  <= data_sync;
              state <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              done    <= 1'b1;
              ack_err <= nack;
              busy    <= 1'b0;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench: a keyboard model clocks frames out of the transmitter and checks timing and bits.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH  = 60;
  localparam int REQ  = 20;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_enable = 1'b0;
  logic [7:0] w_data_in = 8'h00;
  logic       w_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;

  // Open-drain wired-AND of device and host.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .w_enable    (w_enable),
    .w_data_in   (w_data_in),
    .w_ready     (w_ready),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_err     (ack_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One host frame. alive=0: device never clocks. rst_fall>0: reset at that fall. poke: write during SEND.
  task automatic run_frame(input logic [7:0] b, input bit ack, input bit alive,
                           input int rst_fall, input bit poke);
    logic [9:0] got_bits;
    logic [9:0] exp_bits;
    int inh, req, t0, n, d0;
    got_bits = '0;
    exp_bits = {1'b1, (($countones(b) % 2) == 0) ? 1'b1 : 1'b0, b};
    d0 = done_cnt;
    @(negedge clk);
    w_enable = 1'b1;
    w_data_in = b;
    @(negedge clk);
    w_enable = 1'b0;
    check("w_ready_drop", w_ready, 0);
    check("busy_rise", busy, 1);
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < INH + 10) begin inh++; @(negedge clk); end
    check("inhibit_len", inh, INH);
    req = 0;
    while (ps2_clk_oe && ps2_data_oe && req < REQ + 10) begin req++; @(negedge clk); end
    check("req_len", req, REQ);
    check("start_bit", {ps2_clk_oe, ps2_data_oe}, 2'b01);
    t0 = cyc;

    if (!alive) begin
      n = 0;
      while (!done && n < TMO + 100) begin n++; @(negedge clk); end
      check("timeout_at", cyc - t0, TMO);
      check("timeout_err", timeout_err, 1);
      check("timeout_ack_err", ack_err, 0);
      check("timeout_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      @(negedge clk);
      check("timeout_w_ready", w_ready, 1);
      check("timeout_done_cnt", done_cnt - d0, 1);
      $display("[TB] frame %02h no-device: timeout after %0d cycles", b, TMO);
      return;
    end

    wait_cyc(HALF);
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (k == rst_fall) begin
        #1 rst = 1'b1;
        #1;
        check("rst_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check("rst_w_ready", w_ready, 1);
        check("rst_busy", busy, 0);
        wait_cyc(4);
        rst = 1'b0;
        dev_clk = 1'b1;
        wait_cyc(50);
        check("rst_no_done", done_cnt - d0, 0);
        $display("[TB] frame %02h reset at fall %0d: lines released, no done", b, k);
        return;
      end
      if (poke && k == 3) begin
        @(negedge clk);
        w_enable = 1'b1;
        w_data_in = 8'h55;
        @(negedge clk);
        w_enable = 1'b0;
        wait_cyc(HALF - 2);
      end else begin
        wait_cyc(HALF);
      end
      dev_clk = 1'b1;
      if (k <= 10) got_bits[k-1] = ps2_data_in;
      if (k == 11) begin
        dev_data = 1'b1;
        break;
      end
      if (k == 10) begin
        wait_cyc(HALF / 2);
        if (ack) dev_data = 1'b0;
        wait_cyc(HALF - HALF / 2);
      end else begin
        wait_cyc(HALF);
      end
    end

    n = 0;
    while (!done && n < 200) begin n++; @(negedge clk); end
    check("done_seen", done, 1);
    check("ack_err", ack_err, ack ? 0 : 1);
    check("timeout_err_clear", timeout_err, 0);
    check("w_ready_in_done", w_ready, 0);
    check("frame_bits", got_bits, exp_bits);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("flags_low", {ack_err, timeout_err}, 2'b00);
    check("w_ready_back", w_ready, 1);
    check("busy_low", busy, 0);
    check("lines_released", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("done_count", done_cnt - d0, 1);
    $display("[TB] frame %02h ack=%0d bits=%03h ack_err=%0d", b, ack, got_bits, !ack);
  endtask

  initial begin
    rst = 1'b1;
    wait_cyc(3);
    check("reset_w_ready", w_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("reset_flags", {done, ack_err, timeout_err}, 3'b000);
    rst = 1'b0;
    wait_cyc(2);

    run_frame(CMD_SET_LED, 1'b1, 1'b1, 0, 1'b0);
    run_frame(8'h00, 1'b1, 1'b1, 0, 1'b0);
    run_frame(8'h01, 1'b1, 1'b1, 0, 1'b0);
    run_frame(CMD_RESET, 1'b0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_frame(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1, 0, 1'b0);
    end
    run_frame(CMD_ECHO, 1'b1, 1'b0, 0, 1'b0);
    run_frame(CMD_SET_LED, 1'b1, 1'b1, 0, 1'b1);
    run_frame(CMD_SET_LED, 1'b1, 1'b1, 5, 1'b0);
    run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
